// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write
// port between ALU and LSU, plus a busy scoreboard that stalls issue on
// RAW/WAW hazards against in-flight destinations.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iAluValid,
    input  logic [ADDR_W-1:0]   iAluRd,
    input  logic [DATA_W-1:0]   iAluData,
    output logic                oAluReady,
    input  logic                iLsuValid,
    input  logic [ADDR_W-1:0]   iLsuRd,
    input  logic [DATA_W-1:0]   iLsuData,
    output logic                oLsuReady,
    input  logic                iIssueValid,
    input  logic [ADDR_W-1:0]   iIssueRd,
    input  logic [ADDR_W-1:0]   iIssueRs1,
    input  logic [ADDR_W-1:0]   iIssueRs2,
    output logic                oIssueStall,
    output logic                oWriteEn,
    output logic [ADDR_W-1:0]   oRdAddr,
    output logic [DATA_W-1:0]   oWriteData,
    output logic [NUM_REGS-1:0] oBusy
);

    // 0: ALU wins a tie, 1: LSU wins a tie
    logic                prioLsu;
    logic                aluGrant;
    logic                lsuGrant;
    logic                anyGrant;
    logic                doWrite;
    logic [ADDR_W-1:0]   winRd;
    logic [DATA_W-1:0]   winData;
    logic                issueFire;
    logic [NUM_REGS-1:0] busyNext;

    // Round-robin grant and winner selection
    always_comb begin
        aluGrant = iAluValid && (!iLsuValid || !prioLsu);
        lsuGrant = iLsuValid && (!iAluValid ||  prioLsu);
        anyGrant = aluGrant || lsuGrant;
        winRd    = lsuGrant ? iLsuRd   : iAluRd;
        winData  = lsuGrant ? iLsuData : iAluData;
        doWrite  = anyGrant && (winRd != '0);
    end

    assign oAluReady = aluGrant;
    assign oLsuReady = lsuGrant;

    // Hazard check against registered scoreboard; bit 0 is never set so r0 never stalls
    always_comb begin
        oIssueStall = iIssueValid &&
                      (oBusy[iIssueRs1] || oBusy[iIssueRs2] || oBusy[iIssueRd]);
        issueFire   = iIssueValid && !oIssueStall && (iIssueRd != '0);
    end

    // Scoreboard next state: clear on writeback, then set on issue so a newer issue wins
    always_comb begin
        busyNext = oBusy;
        if (doWrite) begin
            busyNext[winRd] = 1'b0;
        end
        if (issueFire) begin
            busyNext[iIssueRd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Priority pointer, registered write port and scoreboard state
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            prioLsu    <= 1'b0;
            oWriteEn   <= 1'b0;
            oRdAddr    <= '0;
            oWriteData <= '0;
            oBusy      <= '0;
        end else begin
            if (aluGrant) begin
                prioLsu <= 1'b1;
            end else if (lsuGrant) begin
                prioLsu <= 1'b0;
            end
            oWriteEn <= doWrite;
            if (doWrite) begin
                oRdAddr    <= winRd;
                oWriteData <= winData;
            end
            oBusy <= busyNext;
        end
    end

endmodule
